// File: rtl/micro_sequencer.sv
// Microprogrammed control unit for the multi-cycle MIPS datapath (microPC + internal microcode ROM).
// Define ILLEGAL_TRAP_EN to lock unknown opcodes in the TRAP microword until reset.
module micro_sequencer #(
  parameter int unsigned UPC_W    = 4,
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                pc_write,
  output logic                ior,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [UPC_W-1:0]    upc,
  output logic                illegal
);

  typedef enum logic [UPC_W-1:0] {
    S_FETCH   = UPC_W'(0),
    S_DECODE  = UPC_W'(1),
    S_MEMADR  = UPC_W'(2),
    S_MEMRD   = UPC_W'(3),
    S_MEMWB   = UPC_W'(4),
    S_MEMWR   = UPC_W'(5),
    S_EXEC    = UPC_W'(6),
    S_RCOMPL  = UPC_W'(7),
    S_BEQ     = UPC_W'(8),
    S_JUMP    = UPC_W'(9),
    S_BNE     = UPC_W'(10),
    S_ADDI_EX = UPC_W'(11),
    S_ADDI_WB = UPC_W'(12),
    S_TRAP    = UPC_W'(13)
  } state_t;

  typedef enum logic [1:0] {
    NXT_SEQ   = 2'b00,
    NXT_DISP1 = 2'b01,
    NXT_DISP2 = 2'b10,
    NXT_RET   = 2'b11
  } next_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);

  state_t           state;
  state_t           state_nxt;
  next_t            w_next;
  logic [UPC_W-1:0] upc_inc;

  logic       w_pc_write, w_beq, w_bne, w_ior, w_mem_read, w_mem_write, w_ir_write;
  logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;
  logic       pc_write_raw;

  // Microcode ROM: one control word per microPC value.
  always_comb begin
    w_pc_write   = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_ior        = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_source  = 2'b00;
    w_illegal    = 1'b0;
    w_next       = NXT_RET;
    case (state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
        w_pc_write  = 1'b1;
        w_next      = NXT_SEQ;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_next      = NXT_DISP1;
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = NXT_DISP2;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_ior      = 1'b1;
        w_next     = NXT_SEQ;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_ior       = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = NXT_SEQ;
      end
      S_RCOMPL: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BEQ, S_BNE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_source = 2'b01;
        w_beq       = (state == S_BEQ);
        w_bne       = (state == S_BNE);
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = NXT_SEQ;
      end
      S_ADDI_WB: begin
        w_reg_write = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_illegal = 1'b1;
      end
`endif
      default: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
        w_pc_write  = 1'b1;
      end
    endcase
  end

  assign upc_inc = state + UPC_W'(1);

  always_comb begin
    state_nxt = S_FETCH;
    case (w_next)
      NXT_SEQ: state_nxt = state_t'(upc_inc);
      NXT_DISP1: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_BNE:       state_nxt = S_BNE;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EX;
`ifdef ILLEGAL_TRAP_EN
          default:      state_nxt = S_TRAP;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      NXT_DISP2: begin
        case (opcode)
          OP_LW:   state_nxt = S_MEMRD;
          OP_SW:   state_nxt = S_MEMWR;
          default: state_nxt = S_FETCH;
        endcase
      end
      default: state_nxt = S_FETCH;
    endcase
`ifdef ILLEGAL_TRAP_EN
    // The 2-bit next field has no self-loop code, so the trap hold is wired here.
    if (state == S_TRAP) state_nxt = S_TRAP;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= S_FETCH;
    else if (!stall) state <= state_nxt;
  end

  assign pc_write_raw = w_pc_write | (w_beq & zero) | (w_bne & ~zero);

  // Reset blanks every output; stall only masks the state-changing enables.
  always_comb begin
    pc_write   = 1'b0;
    ior        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = '0;
    alu_op     = '0;
    pc_source  = '0;
    upc        = '0;
    illegal    = 1'b0;
    if (rst_n) begin
      pc_write   = pc_write_raw & ~stall;
      ior        = w_ior;
      mem_read   = w_mem_read;
      mem_write  = w_mem_write & ~stall;
      ir_write   = w_ir_write & ~stall;
      mem_to_reg = w_mem_to_reg;
      reg_dst    = w_reg_dst;
      reg_write  = w_reg_write & ~stall;
      alu_src_a  = w_alu_src_a;
      alu_src_b  = w_alu_src_b;
      alu_op     = w_alu_op;
      pc_source  = w_pc_source;
      upc        = state;
      illegal    = w_illegal;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: per-cycle vector table through a scoreboard queue,
// plus hand-written reset sequences. Follows ILLEGAL_TRAP_EN the same way as the design.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, stall, zero;
  logic [5:0] opcode;
  logic       pc_write, ior, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] upc;

  always #5 clk = ~clk;

  micro_sequencer #(.UPC_W(4), .OPCODE_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .ior(ior), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .upc(upc), .illegal(illegal)
  );

  typedef struct {
    logic [5:0]  opc;
    logic        z;
    logic        st;
    logic [3:0]  upc;
    logic [15:0] ctl;
    string       name;
  } vec_t;

  typedef struct {
    logic [3:0]  upc;
    logic [15:0] ctl;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] act_ctl;
  assign act_ctl = {pc_write, ior, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                    alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  logic [15:0] c_fetch, c_fetch_st, c_decode, c_memadr, c_memrd, c_memwb, c_memwr, c_memwr_st;
  logic [15:0] c_exec, c_rcompl, c_br_t, c_br_n, c_jump, c_addi_ex, c_addi_wb, c_trap;

  function automatic logic [15:0] mk(input logic pcw, iorb, mr, mw, irw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, ps, input logic ill);
    return {pcw, iorb, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
  endfunction

  task automatic add(input logic [5:0] opc, input logic z, input logic st,
                     input logic [3:0] u, input logic [15:0] c, input string name);
    vec_t v;
    v.opc = opc; v.z = z; v.st = st; v.upc = u; v.ctl = c; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] eu, input logic [15:0] ec);
    n_checks++;
    if (upc === eu) n_pass++;
    else $display("FAIL %s upc: got %0d want %0d", name, upc, eu);
    n_checks++;
    if (act_ctl === ec) n_pass++;
    else $display("FAIL %s ctl: got %b want %b", name, act_ctl, ec);
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb.pop_front();
      check(e.name, e.upc, e.ctl);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic drive_push(input vec_t v);
    exp_t e;
    opcode = v.opc; zero = v.z; stall = v.st;
    e.upc = v.upc; e.ctl = v.ctl; e.name = v.name;
    sb.push_back(e);
    @(negedge clk);
    check_head();
  endtask

  task automatic apply(input vec_t v);
    drive_push(v);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_args(input logic [5:0] opc, input logic z, input logic st,
                            input logic [3:0] u, input logic [15:0] c, input string name);
    vec_t v;
    v.opc = opc; v.z = z; v.st = st; v.upc = u; v.ctl = c; v.name = name;
    apply(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //            pcw ior mr mw irw m2r rd rw asa asb    aop    ps     ill
    c_fetch    = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    c_fetch_st = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    c_decode   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    c_memadr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    c_memrd    = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    c_memwb    = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    c_memwr    = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    c_memwr_st = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    c_exec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
    c_rcompl   = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    c_br_t     = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    c_br_n     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    c_jump     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
    c_addi_ex  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    c_addi_wb  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    c_trap     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

    // lw, R-type, sw
    add(6'h23, 0, 0, 0, c_fetch,  "lw_fetch");
    add(6'h23, 0, 0, 1, c_decode, "lw_decode");
    add(6'h23, 0, 0, 2, c_memadr, "lw_memadr");
    add(6'h23, 0, 0, 3, c_memrd,  "lw_memrd");
    add(6'h23, 0, 0, 4, c_memwb,  "lw_memwb");
    add(6'h00, 0, 0, 0, c_fetch,  "r_fetch");
    add(6'h00, 0, 0, 1, c_decode, "r_decode");
    add(6'h00, 0, 0, 6, c_exec,   "r_exec");
    add(6'h00, 0, 0, 7, c_rcompl, "r_rcompl");
    add(6'h2B, 0, 0, 0, c_fetch,  "sw_fetch");
    add(6'h2B, 0, 0, 1, c_decode, "sw_decode");
    add(6'h2B, 0, 0, 2, c_memadr, "sw_memadr");
    add(6'h2B, 0, 0, 5, c_memwr,  "sw_memwr");
    // branches and jump
    add(6'h04, 0, 0, 0, c_fetch,  "beq_t_fetch");
    add(6'h04, 0, 0, 1, c_decode, "beq_t_decode");
    add(6'h04, 1, 0, 8, c_br_t,   "beq_taken");
    add(6'h04, 0, 0, 0, c_fetch,  "beq_n_fetch");
    add(6'h04, 0, 0, 1, c_decode, "beq_n_decode");
    add(6'h04, 0, 0, 8, c_br_n,   "beq_not_taken");
    add(6'h05, 0, 0, 0, c_fetch,  "bne_t_fetch");
    add(6'h05, 0, 0, 1, c_decode, "bne_t_decode");
    add(6'h05, 0, 0, 10, c_br_t,  "bne_taken");
    add(6'h05, 0, 0, 0, c_fetch,  "bne_n_fetch");
    add(6'h05, 0, 0, 1, c_decode, "bne_n_decode");
    add(6'h05, 1, 0, 10, c_br_n,  "bne_not_taken");
    add(6'h02, 0, 0, 0, c_fetch,  "j_fetch");
    add(6'h02, 0, 0, 1, c_decode, "j_decode");
    add(6'h02, 0, 0, 9, c_jump,   "j_jump");
    add(6'h08, 0, 0, 0, c_fetch,  "addi_fetch");
    add(6'h08, 0, 0, 1, c_decode, "addi_decode");
    add(6'h08, 0, 0, 11, c_addi_ex, "addi_ex");
    add(6'h08, 0, 0, 12, c_addi_wb, "addi_wb");
    // stalls: sw write, fetch, branch
    add(6'h2B, 0, 0, 0, c_fetch,    "sws_fetch");
    add(6'h2B, 0, 0, 1, c_decode,   "sws_decode");
    add(6'h2B, 0, 0, 2, c_memadr,   "sws_memadr");
    add(6'h2B, 0, 1, 5, c_memwr_st, "sws_stall1");
    add(6'h2B, 0, 1, 5, c_memwr_st, "sws_stall2");
    add(6'h2B, 0, 1, 5, c_memwr_st, "sws_stall3");
    add(6'h2B, 0, 0, 5, c_memwr,    "sws_release");
    add(6'h04, 0, 1, 0, c_fetch_st, "fetch_stalled");
    add(6'h04, 0, 0, 0, c_fetch,    "fetch_release");
    add(6'h04, 0, 0, 1, c_decode,   "beqs_decode");
    add(6'h04, 1, 1, 8, c_br_n,     "beq_stalled");
    add(6'h04, 1, 0, 8, c_br_t,     "beq_release");
    // illegal opcode
    add(6'h3F, 0, 0, 0, c_fetch,  "ill_fetch");
    add(6'h3F, 0, 0, 1, c_decode, "ill_decode");
`ifdef ILLEGAL_TRAP_EN
    add(6'h3F, 0, 0, 13, c_trap,  "trap_enter");
    add(6'h00, 0, 0, 13, c_trap,  "trap_hold1");
    add(6'h23, 1, 0, 13, c_trap,  "trap_hold2");
`else
    add(6'h3F, 0, 0, 0, c_fetch,  "ill_nop_fetch");
    add(6'h3F, 0, 0, 1, c_decode, "ill_nop_decode");
    add(6'h3F, 0, 0, 0, c_fetch,  "ill_nop_again");
`endif

    rst_n = 1'b0; stall = 1'b0; zero = 1'b1; opcode = 6'h23;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 4'd0, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset clears whatever state the table left behind (including a held trap).
    rst_n = 1'b0;
    #1 check("reset_clear", 4'd0, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_args(6'h23, 0, 0, 0, c_fetch,  "mid_fetch");
    apply_args(6'h23, 0, 0, 1, c_decode, "mid_decode");
    apply_args(6'h23, 0, 0, 2, c_memadr, "mid_memadr");
    v.opc = 6'h23; v.z = 1'b0; v.st = 1'b0; v.upc = 4'd3; v.ctl = c_memrd; v.name = "mid_memrd";
    drive_push(v);
    #1 rst_n = 1'b0;
    #1 check("mid_abort", 4'd0, 16'h0000);
    @(posedge clk);
    #1 check("mid_abort_edge", 4'd0, 16'h0000);
    rst_n = 1'b1;
    apply_args(6'h23, 0, 0, 0, c_fetch,  "resume_fetch");
    apply_args(6'h23, 0, 0, 1, c_decode, "resume_decode");
    apply_args(6'h23, 0, 0, 2, c_memadr, "resume_memadr");

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard drain: got %0d entries left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
